// File: rtl/serial_frame_tx_pkg.sv
// Shared constants for the serial framing transmitter and its companion sync detector.
package serial_frame_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SYNC = 4'b0010,
    ST_DATA = 4'b0100,
    ST_GAP  = 4'b1000
  } tx_state_e;

  localparam logic [7:0]  SYNC_PAT_DEFAULT = 8'b1010_1010;
  localparam int unsigned SYNC_LEN_DEFAULT = 8;
  localparam int unsigned GAP_LEN_DEFAULT  = 2;

endpackage

// File: rtl/serial_frame_tx_shift_reg.sv
// 8-bit loadable MSB-first shift register; load wins over shift, zeros shift in.
module frame_shift_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= data_i;
    end else if (shift_i) begin
      q_q <= {q_q[6:0], 1'b0};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Serial framing transmitter: sync word, then payload bytes MSB first, then an idle gap.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter logic [7:0]  SYNC_PAT = SYNC_PAT_DEFAULT,
  parameter int unsigned SYNC_LEN = SYNC_LEN_DEFAULT,
  parameter int unsigned GAP_LEN  = GAP_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dout,
  output logic       dout_en,
  output logic       busy,
  output logic       underrun
);

  tx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       dout_q, dout_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       under_q, under_d;
  logic       load, shift_en, xfer;
  logic [7:0] shift_q;

  frame_shift_reg u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift_en),
    .data_i  (tx_data),
    .q_o     (shift_q)
  );

  assign tx_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_DATA) && (cnt_q == '0) && !last_q);
  assign xfer     = tx_valid && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      dout_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      under_q <= under_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          last_d  = tx_last;
          cnt_d   = 4'(SYNC_LEN - 1);
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          cnt_d   = 4'd7;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else if (xfer) begin
          load   = 1'b1;
          last_d = tx_last;
          cnt_d  = 4'd7;
        end else begin
          cnt_d   = 4'(GAP_LEN - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so dout lines up with the
  // cycle the FSM is in; the next MSB is taken from the shifter's input side.
  always_comb begin
    dout_d  = 1'b0;
    en_d    = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    under_d = (state_q == ST_DATA) && (cnt_q == '0) && !last_q && !xfer;
    unique case (state_d)
      ST_SYNC: begin
        dout_d = SYNC_PAT[cnt_d[2:0]];
        en_d   = 1'b1;
      end
      ST_DATA: begin
        en_d = 1'b1;
        if (load) begin
          dout_d = tx_data[7];
        end else if (shift_en) begin
          dout_d = shift_q[6];
        end else begin
          dout_d = shift_q[7];
        end
      end
      default: begin
        dout_d = 1'b0;
        en_d   = 1'b0;
      end
    endcase
  end

  assign dout     = dout_q;
  assign dout_en  = en_q;
  assign busy     = busy_q;
  assign underrun = under_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: per-cycle vector table plus reset and loopback sequences.
module tb_serial_frame_tx;
  import serial_frame_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       dout;
  logic       dout_en;
  logic       busy;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       r;
    logic       o;
    logic       e;
    logic       b;
    logic       u;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  serial_frame_tx #(
    .SYNC_PAT (SYNC_PAT_DEFAULT),
    .SYNC_LEN (SYNC_LEN_DEFAULT),
    .GAP_LEN  (GAP_LEN_DEFAULT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .dout     (dout),
    .dout_en  (dout_en),
    .busy     (busy),
    .underrun (underrun)
  );

  // Downstream sync detector: Mealy match on the incoming bit, registered flag.
  logic [7:0] det_hist;
  logic       det_flag;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_hist <= '0;
      det_flag <= 1'b0;
    end else begin
      det_flag <= dout_en && ({det_hist[6:0], dout} == SYNC_PAT_DEFAULT);
      if (dout_en) det_hist <= {det_hist[6:0], dout};
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input string t, input logic v, input logic [7:0] d, input logic l,
                     input logic r, input logic o, input logic e, input logic b, input logic u);
    vec_t x;
    x.tag = t; x.v = v; x.d = d; x.l = l;
    x.r = r; x.o = o; x.e = e; x.b = b; x.u = u;
    vecs.push_back(x);
  endtask

  task automatic add_sync(input string t, input logic v, input logic [7:0] d, input logic l);
    for (int i = int'(SYNC_LEN_DEFAULT) - 1; i >= 0; i--)
      add(t, v, d, l, 1'b0, SYNC_PAT_DEFAULT[i], 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_byte(input string t, input logic [7:0] pb, input logic rdy_last,
                          input logic v, input logic [7:0] d, input logic l);
    for (int i = 7; i >= 0; i--)
      add(t, v, d, l, (i == 0) ? rdy_last : 1'b0, pb[i], 1'b1, 1'b1, 1'b0);
  endtask

  task automatic add_gap(input string t, input logic first_under,
                         input logic v, input logic [7:0] d, input logic l);
    for (int i = 0; i < int'(GAP_LEN_DEFAULT); i++)
      add(t, v, d, l, 1'b0, 1'b0, 1'b0, 1'b1, (i == 0) ? first_under : 1'b0);
  endtask

  initial begin
    int flags;
    int flag_k;
    int n;

    // Single byte 0x3C, last.
    add("t1", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_sync("t1", 1'b0, 8'h00, 1'b0);
    add_byte("t1", 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    add_gap("t1", 1'b0, 1'b0, 8'h00, 1'b0);
    // 0xA5 then 0x0F back to back, second byte presented throughout.
    add("t2", 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_sync("t2", 1'b1, 8'h0F, 1'b1);
    add_byte("t2", 8'hA5, 1'b1, 1'b1, 8'h0F, 1'b1);
    add_byte("t2", 8'h0F, 1'b0, 1'b0, 8'h00, 1'b0);
    add_gap("t2", 1'b0, 1'b0, 8'h00, 1'b0);
    // 0x81 without last and no follow-up byte: underrun.
    add("t3", 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_sync("t3", 1'b0, 8'h00, 1'b0);
    add_byte("t3", 8'h81, 1'b1, 1'b0, 8'h00, 1'b0);
    add_gap("t3", 1'b1, 1'b0, 8'h00, 1'b0);
    // tx_valid held high through the whole frame and gap.
    add("t4", 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_sync("t4", 1'b1, 8'h55, 1'b1);
    add_byte("t4", 8'h55, 1'b0, 1'b1, 8'h55, 1'b1);
    add_gap("t4", 1'b0, 1'b1, 8'h55, 1'b1);
    add("t4", 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_sync("t4", 1'b0, 8'h00, 1'b0);
    add_byte("t4", 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
    add_gap("t4", 1'b0, 1'b0, 8'h00, 1'b0);
    add("t4", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst dout", dout, 1'b0);
    check("rst dout_en", dout_en, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst underrun", underrun, 1'b0);
    rst = 1'b0;
    #1 check("rst tx_ready", tx_ready, 1'b1);

    foreach (vecs[k]) begin
      @(negedge clk);
      tx_valid = vecs[k].v; tx_data = vecs[k].d; tx_last = vecs[k].l;
      #1;
      check($sformatf("%s[%0d] tx_ready", vecs[k].tag, k), tx_ready, vecs[k].r);
      check($sformatf("%s[%0d] dout", vecs[k].tag, k), dout, vecs[k].o);
      check($sformatf("%s[%0d] dout_en", vecs[k].tag, k), dout_en, vecs[k].e);
      check($sformatf("%s[%0d] busy", vecs[k].tag, k), busy, vecs[k].b);
      check($sformatf("%s[%0d] underrun", vecs[k].tag, k), underrun, vecs[k].u);
    end

    // Reset in the fifth cycle of a frame, with a byte offered during reset.
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'hC3; tx_last = 1'b1;
    #1 check("rs start ready", tx_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    #1 check("rs pre en", dout_en, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rs dout", dout, 1'b0);
    check("rs dout_en", dout_en, 1'b0);
    check("rs busy", busy, 1'b0);
    tx_valid = 1'b1; tx_data = 8'hF0; tx_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rs held busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("rs rel ready", tx_ready, 1'b1);
    check("rs rel busy", busy, 1'b0);
    check("rs rel en", dout_en, 1'b0);
    for (int i = int'(SYNC_LEN_DEFAULT) - 1; i >= 0; i--) begin
      @(negedge clk);
      tx_valid = 1'b0;
      #1;
      check($sformatf("rs sync%0d dout", i), dout, SYNC_PAT_DEFAULT[i]);
      check($sformatf("rs sync%0d en", i), dout_en, 1'b1);
    end
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rs drain busy", busy, 1'b0);

    // Loopback: sync word then payload 0x00 must give one flag just after the last sync bit.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
    flags = 0; flag_k = -1;
    for (int k = 1; k <= int'(SYNC_LEN_DEFAULT + 8 + GAP_LEN_DEFAULT) + 2; k++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      #1;
      if (det_flag) begin
        flags++;
        flag_k = k;
      end
    end
    check_int("lb flag count", flags, 1);
    check_int("lb flag cycle", flag_k, int'(SYNC_LEN_DEFAULT) + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
